// File: rtl/ascon_pkg.sv
// Shared types and widths for the ASCON core session arbiter.
//   arb_state_e : session state machine encoding
//   ASCON_KEY_W : key / nonce / tag width
//   ASCON_BLK_W : stream data width per requester
package ascon_pkg;

  localparam int unsigned NUM_REQ     = 2;
  localparam int unsigned ASCON_KEY_W = 128;
  localparam int unsigned ASCON_BLK_W = 64;
  localparam int unsigned BLK_CNT_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    HOLD,
    FAULT
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick.
//   req_i        : pending requests
//   last_owner_i : requester served most recently (loses a tie)
//   gnt_c_o      : one-hot winner, 0 when nothing is requested (combinational)
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic [1:0] gnt_c_o
);

  // The requester that did not own the core last time has priority.
  always_comb begin
    gnt_c_o = 2'b00;
    if (last_owner_i) begin
      if (req_i[0])      gnt_c_o = 2'b01;
      else if (req_i[1]) gnt_c_o = 2'b10;
    end else begin
      if (req_i[1])      gnt_c_o = 2'b10;
      else if (req_i[0]) gnt_c_o = 2'b01;
    end
  end

endmodule

// File: rtl/ascon_core_arbiter.sv
// Session-level arbiter sharing one ascon_aead core between the host front-end
// (requester 0) and the SNN result packer (requester 1).
//   clk, rst_n          : clock, asynchronous active-low reset
//   req/req_decrypt     : per-requester session request and mode
//   req_key/req_nonce   : per-requester key/nonce, [127:0] = requester 0
//   grant               : one-hot session owner
//   s_* / m_*           : per-requester input/output streams (routed to owner)
//   done/tag/auth_fail  : session completion pulse and latched result
//   blk_cnt             : input blocks accepted in the last session (saturating)
//   fault               : sticky stall flag, cleared only by reset
//   core_*              : connection to the shared ascon_aead core
// Stream routing is combinational so RUN adds no latency; all other outputs
// are registered.
module ascon_core_arbiter
  import ascon_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_decrypt,
  input  logic [NUM_REQ*ASCON_KEY_W-1:0]   req_key,
  input  logic [NUM_REQ*ASCON_KEY_W-1:0]   req_nonce,
  output logic [NUM_REQ-1:0]               grant,
  input  logic [NUM_REQ-1:0]               s_tvalid,
  input  logic [NUM_REQ-1:0]               s_tlast,
  input  logic [NUM_REQ*ASCON_BLK_W-1:0]   s_tdata,
  output logic [NUM_REQ-1:0]               s_tready,
  output logic [NUM_REQ-1:0]               m_tvalid,
  output logic [NUM_REQ-1:0]               m_tlast,
  output logic [ASCON_BLK_W-1:0]           m_tdata,
  input  logic [NUM_REQ-1:0]               m_tready,
  output logic [NUM_REQ-1:0]               done,
  output logic [ASCON_KEY_W-1:0]           tag,
  output logic                             auth_fail,
  output logic [BLK_CNT_W-1:0]             blk_cnt,
  output logic                             fault,
  output logic                             core_start_enc,
  output logic                             core_start_dec,
  output logic [ASCON_KEY_W-1:0]           core_key,
  output logic [ASCON_KEY_W-1:0]           core_nonce,
  output logic                             core_s_tvalid,
  input  logic                             core_s_tready,
  output logic [ASCON_BLK_W-1:0]           core_s_tdata,
  output logic                             core_s_tlast,
  input  logic                             core_m_tvalid,
  output logic                             core_m_tready,
  input  logic [ASCON_BLK_W-1:0]           core_m_tdata,
  input  logic                             core_m_tlast,
  input  logic [ASCON_KEY_W-1:0]           core_tag,
  input  logic                             core_tag_valid,
  input  logic                             core_auth_fail,
  input  logic                             core_busy
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e             state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_owner_q, last_owner_d;
  logic                   dec_q, dec_d;
  logic [ASCON_KEY_W-1:0] key_q, key_d;
  logic [ASCON_KEY_W-1:0] nonce_q, nonce_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   start_enc_q, start_enc_d;
  logic                   start_dec_q, start_dec_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [ASCON_KEY_W-1:0] tag_q, tag_d;
  logic                   auth_fail_q, auth_fail_d;
  logic [BLK_CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic                   fault_q, fault_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;

  logic [1:0] pick_c;
  logic       run_c;
  logic       s_hs_c;
  logic       m_hs_c;

  rr_arbiter2 u_rr (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .gnt_c_o      (pick_c)
  );

  // Stream routing: only the owner is connected, and only while in RUN.
  always_comb begin
    run_c         = (state_q == RUN);
    s_tready      = '0;
    m_tvalid      = '0;
    m_tlast       = '0;
    core_s_tvalid = 1'b0;
    core_s_tlast  = 1'b0;
    core_s_tdata  = '0;
    core_m_tready = 1'b0;
    m_tdata       = '0;
    if (run_c) begin
      core_s_tvalid     = s_tvalid[owner_q];
      core_s_tlast      = s_tlast[owner_q];
      core_s_tdata      = owner_q ? s_tdata[2*ASCON_BLK_W-1:ASCON_BLK_W]
                                  : s_tdata[ASCON_BLK_W-1:0];
      s_tready[owner_q] = core_s_tready;
      m_tvalid[owner_q] = core_m_tvalid;
      m_tlast[owner_q]  = core_m_tlast;
      core_m_tready     = m_tready[owner_q];
      m_tdata           = core_m_tdata;
    end
    s_hs_c = core_s_tvalid & core_s_tready;
    m_hs_c = core_m_tvalid & core_m_tready;
  end

  // Session state machine and registered outputs.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    dec_d        = dec_q;
    key_d        = key_q;
    nonce_d      = nonce_q;
    grant_d      = grant_q;
    start_enc_d  = 1'b0;
    start_dec_d  = 1'b0;
    done_d       = '0;
    tag_d        = tag_q;
    auth_fail_d  = auth_fail_q;
    blk_cnt_d    = blk_cnt_q;
    fault_d      = fault_q;
    to_cnt_d     = to_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (|pick_c) begin
          owner_d     = pick_c[1];
          key_d       = pick_c[1] ? req_key[2*ASCON_KEY_W-1:ASCON_KEY_W]
                                  : req_key[ASCON_KEY_W-1:0];
          nonce_d     = pick_c[1] ? req_nonce[2*ASCON_KEY_W-1:ASCON_KEY_W]
                                  : req_nonce[ASCON_KEY_W-1:0];
          dec_d       = req_decrypt[pick_c[1]];
          grant_d     = pick_c;
          start_enc_d = ~req_decrypt[pick_c[1]];
          start_dec_d = req_decrypt[pick_c[1]];
          state_d     = START;
        end
      end
      START: begin
        blk_cnt_d = '0;
        to_cnt_d  = '0;
        state_d   = RUN;
      end
      RUN: begin
        if (s_hs_c && (blk_cnt_q != {BLK_CNT_W{1'b1}})) begin
          blk_cnt_d = blk_cnt_q + BLK_CNT_W'(1);
        end
        if (s_hs_c || m_hs_c) to_cnt_d = '0;
        else                  to_cnt_d = to_cnt_q + TO_W'(1);
        // A tag in the same cycle as the last idle count still completes the session.
        if (core_tag_valid) begin
          tag_d       = core_tag;
          auth_fail_d = core_auth_fail;
          done_d      = owner_q ? 2'b10 : 2'b01;
          state_d     = HOLD;
        end else if (to_cnt_d == TO_W'(TIMEOUT_CYCLES)) begin
          fault_d = 1'b1;
          grant_d = '0;
          state_d = FAULT;
        end
      end
      HOLD: begin
        if (!core_busy && !req[owner_q]) begin
          grant_d      = '0;
          last_owner_d = owner_q;
          state_d      = IDLE;
        end
      end
      FAULT: begin
        grant_d = '0;
        fault_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      dec_q        <= 1'b0;
      key_q        <= '0;
      nonce_q      <= '0;
      grant_q      <= '0;
      start_enc_q  <= 1'b0;
      start_dec_q  <= 1'b0;
      done_q       <= '0;
      tag_q        <= '0;
      auth_fail_q  <= 1'b0;
      blk_cnt_q    <= '0;
      fault_q      <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      dec_q        <= dec_d;
      key_q        <= key_d;
      nonce_q      <= nonce_d;
      grant_q      <= grant_d;
      start_enc_q  <= start_enc_d;
      start_dec_q  <= start_dec_d;
      done_q       <= done_d;
      tag_q        <= tag_d;
      auth_fail_q  <= auth_fail_d;
      blk_cnt_q    <= blk_cnt_d;
      fault_q      <= fault_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign grant          = grant_q;
  assign core_start_enc = start_enc_q;
  assign core_start_dec = start_dec_q;
  assign core_key       = key_q;
  assign core_nonce     = nonce_q;
  assign done           = done_q;
  assign tag            = tag_q;
  assign auth_fail      = auth_fail_q;
  assign blk_cnt        = blk_cnt_q;
  assign fault          = fault_q;

endmodule
